// File: rtl/time_set_ctrl.sv
// time_set_ctrl: debounces three board keys and runs the hour/minute edit
// state machine that stages a 24-hour time and commits it with a load strobe.
module time_set_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk_50,
  input  logic       clr,
  input  logic       key_mode_n,
  input  logic       key_up_n,
  input  logic       key_down_n,
  output logic [4:0] h,
  output logic [5:0] m,
  output logic       load,
  output logic       edit_h,
  output logic       edit_m
);

  localparam int unsigned NKEYS  = 3;
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned K_DOWN = 0;
  localparam int unsigned K_UP   = 1;
  localparam int unsigned K_MODE = 2;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOUR_W-1:0] HOUR_MAX = HOUR_W'(23);
  localparam logic [MIN_W-1:0]  MIN_MAX  = MIN_W'(59);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SET_H  = 2'd1,
    SET_M  = 2'd2,
    COMMIT = 2'd3
  } state_e;

  // Key vectors: bit 2 = mode, bit 1 = up, bit 0 = down; 1 = released
  logic [NKEYS-1:0] key_raw;
  logic [NKEYS-1:0] sync1_q, sync2_q;
  logic [NKEYS-1:0] deb_q, deb_d;
  logic [NKEYS-1:0] ev_q, ev_d;
  logic [CNT_W-1:0] cnt_q [NKEYS];
  logic [CNT_W-1:0] cnt_d [NKEYS];

  state_e state_q, state_d;

  logic [HOUR_W-1:0] h_q, h_d;
  logic [MIN_W-1:0]  m_q, m_d;
  logic              load_q, load_d;
  logic              edit_h_q, edit_h_d;
  logic              edit_m_q, edit_m_d;

  logic mode_ev, up_only, down_only;

  assign key_raw = {key_mode_n, key_up_n, key_down_n};

  // Synchronizers, debounce counters and registered press events
  always_ff @(posedge clk_50) begin
    if (clr) begin
      sync1_q <= '1;
      sync2_q <= '1;
      deb_q   <= '1;
      ev_q    <= '0;
      for (int unsigned i = 0; i < NKEYS; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      ev_q    <= ev_d;
      for (int unsigned i = 0; i < NKEYS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Count while the synchronized level disagrees; flip after DEBOUNCE_CYCLES
  always_comb begin
    deb_d = deb_q;
    ev_d  = '0;
    for (int unsigned i = 0; i < NKEYS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync2_q[i];
          // Only released->pressed produces an event
          ev_d[i]  = deb_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign mode_ev   = ev_q[K_MODE];
  assign up_only   = ev_q[K_UP] & ~ev_q[K_DOWN];
  assign down_only = ev_q[K_DOWN] & ~ev_q[K_UP];

  // State register
  always_ff @(posedge clk_50) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: mode steps through the fields, commit lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mode_ev) state_d = SET_H;
      SET_H:   if (mode_ev) state_d = SET_M;
      SET_M:   if (mode_ev) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next values: field edits with explicit wrap, strobes from next state
  always_comb begin
    h_d      = h_q;
    m_d      = m_q;
    load_d   = (state_d == COMMIT);
    edit_h_d = (state_d == SET_H);
    edit_m_d = (state_d == SET_M);
    case (state_q)
      SET_H: begin
        if (!mode_ev) begin
          if (up_only)        h_d = (h_q == HOUR_MAX) ? '0 : h_q + HOUR_W'(1);
          else if (down_only) h_d = (h_q == '0) ? HOUR_MAX : h_q - HOUR_W'(1);
        end
      end
      SET_M: begin
        if (!mode_ev) begin
          if (up_only)        m_d = (m_q == MIN_MAX) ? '0 : m_q + MIN_W'(1);
          else if (down_only) m_d = (m_q == '0) ? MIN_MAX : m_q - MIN_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk_50) begin
    if (clr) begin
      h_q      <= '0;
      m_q      <= '0;
      load_q   <= 1'b0;
      edit_h_q <= 1'b0;
      edit_m_q <= 1'b0;
    end else begin
      h_q      <= h_d;
      m_q      <= m_d;
      load_q   <= load_d;
      edit_h_q <= edit_h_d;
      edit_m_q <= edit_m_d;
    end
  end

  assign h      = h_q;
  assign m      = m_q;
  assign load   = load_q;
  assign edit_h = edit_h_q;
  assign edit_m = edit_m_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed bench for time_set_ctrl with a commit scoreboard.
module tb_time_set_ctrl;

  localparam int unsigned DEB = 4;
  localparam int K_MODE = 0;
  localparam int K_UP   = 1;
  localparam int K_DOWN = 2;

  logic       clk_50 = 1'b0;
  logic       clr;
  logic       key_mode_n, key_up_n, key_down_n;
  logic [4:0] h;
  logic [5:0] m;
  logic       load, edit_h, edit_m;

  int tests = 0;
  int fails = 0;
  int loads = 0;
  logic [10:0] sb [$];

  time_set_ctrl #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk_50     (clk_50),
    .clr        (clr),
    .key_mode_n (key_mode_n),
    .key_up_n   (key_up_n),
    .key_down_n (key_down_n),
    .h          (h),
    .m          (m),
    .load       (load),
    .edit_h     (edit_h),
    .edit_m     (edit_m)
  );

  always #5 clk_50 = ~clk_50;

  task automatic chk(input string tag, input int obs, input int exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      K_MODE:  key_mode_n = v;
      K_UP:    key_up_n   = v;
      default: key_down_n = v;
    endcase
  endtask

  // One clean press-and-release, long enough for both edges to debounce
  task automatic press(input int k);
    set_key(k, 1'b0);
    step(8);
    set_key(k, 1'b1);
    step(8);
  endtask

  // Scoreboard side: every load must match the oldest expected {h,m}
  always @(negedge clk_50) begin
    if (!clr) chk("edit_exclusive", int'(edit_h & edit_m), 0);
    if (load) begin
      loads++;
      if (sb.size() == 0) begin
        chk("unexpected_load", 1, 0);
      end else begin
        logic [10:0] e;
        e = sb.pop_front();
        chk("load_h", int'(h), int'(e[10:6]));
        chk("load_m", int'(m), int'(e[5:0]));
      end
    end
  end

  initial begin
    clr = 1'b1;
    key_mode_n = 1'b1;
    key_up_n   = 1'b1;
    key_down_n = 1'b1;
    step(2);
    clr = 1'b0;
    chk("rst_h", int'(h), 0);
    chk("rst_m", int'(m), 0);
    chk("rst_load", int'(load), 0);
    chk("rst_edit_h", int'(edit_h), 0);
    chk("rst_edit_m", int'(edit_m), 0);

    // Idle with keys released
    for (int i = 0; i < 50; i++) begin
      step(1);
      chk("idle_load", int'(load), 0);
      chk("idle_edit_h", int'(edit_h), 0);
      chk("idle_edit_m", int'(edit_m), 0);
    end
    chk("idle_h", int'(h), 0);
    chk("idle_m", int'(m), 0);

    // Basic session: 5 up on hours, 3 down on minutes
    press(K_MODE);
    chk("seth_edit_h", int'(edit_h), 1);
    chk("seth_edit_m", int'(edit_m), 0);
    for (int i = 0; i < 5; i++) press(K_UP);
    chk("seth_h5", int'(h), 5);
    press(K_MODE);
    chk("setm_edit_h", int'(edit_h), 0);
    chk("setm_edit_m", int'(edit_m), 1);
    for (int i = 0; i < 3; i++) press(K_DOWN);
    chk("setm_m57", int'(m), 57);
    chk("setm_h_kept", int'(h), 5);
    sb.push_back({5'd5, 6'd57});
    press(K_MODE);
    chk("post_commit_edit_h", int'(edit_h), 0);
    chk("post_commit_edit_m", int'(edit_m), 0);
    chk("post_commit_load", int'(load), 0);
    chk("loads_after_1", loads, 1);

    // Wrap checks, starting from staged 5:57
    press(K_MODE);
    chk("resume_h", int'(h), 5);
    for (int i = 0; i < 6; i++) press(K_DOWN);
    chk("h_down_wrap", int'(h), 23);
    press(K_UP);
    chk("h_up_wrap", int'(h), 0);
    press(K_DOWN);
    chk("h_down_wrap2", int'(h), 23);
    press(K_MODE);
    press(K_UP);
    press(K_UP);
    chk("m_59", int'(m), 59);
    press(K_UP);
    chk("m_up_wrap", int'(m), 0);
    sb.push_back({5'd23, 6'd0});
    press(K_MODE);
    chk("loads_after_2", loads, 2);

    // Bounce on up: 3 low, 1 high, then held low
    press(K_MODE);
    chk("bounce_pre_h", int'(h), 23);
    key_up_n = 1'b0;
    step(3);
    key_up_n = 1'b1;
    step(1);
    key_up_n = 1'b0;
    step(6);
    chk("bounce_before_edge", int'(h), 23);
    step(1);
    chk("bounce_at_edge", int'(h), 0);
    step(200);
    chk("bounce_held", int'(h), 0);
    key_up_n = 1'b1;
    step(8);
    chk("bounce_released", int'(h), 0);

    // Simultaneous up+down in SET_M
    press(K_MODE);
    press(K_UP);
    chk("sim_pre_m", int'(m), 1);
    key_up_n   = 1'b0;
    key_down_n = 1'b0;
    step(8);
    chk("sim_updown_m", int'(m), 1);
    chk("sim_updown_edit_m", int'(edit_m), 1);
    key_up_n   = 1'b1;
    key_down_n = 1'b1;
    step(8);
    sb.push_back({5'd0, 6'd1});
    press(K_MODE);

    // Simultaneous mode+up in SET_H
    press(K_MODE);
    chk("sim_pre_edit_h", int'(edit_h), 1);
    key_mode_n = 1'b0;
    key_up_n   = 1'b0;
    step(8);
    chk("sim_modeup_edit_m", int'(edit_m), 1);
    chk("sim_modeup_edit_h", int'(edit_h), 0);
    chk("sim_modeup_h", int'(h), 0);
    key_mode_n = 1'b1;
    key_up_n   = 1'b1;
    step(8);
    sb.push_back({5'd0, 6'd1});
    press(K_MODE);
    chk("loads_after_4", loads, 4);

    // Reset mid-edit at 7:30 in SET_M
    press(K_MODE);
    for (int i = 0; i < 7; i++) press(K_UP);
    press(K_MODE);
    for (int i = 0; i < 29; i++) press(K_UP);
    chk("mid_h7", int'(h), 7);
    chk("mid_m30", int'(m), 30);
    chk("mid_edit_m", int'(edit_m), 1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clr_h", int'(h), 0);
    chk("clr_m", int'(m), 0);
    chk("clr_edit_h", int'(edit_h), 0);
    chk("clr_edit_m", int'(edit_m), 0);
    chk("clr_load", int'(load), 0);

    // Up in IDLE is ignored
    press(K_UP);
    chk("idle_up_h", int'(h), 0);
    chk("idle_up_m", int'(m), 0);
    chk("idle_up_edit_h", int'(edit_h), 0);
    step(10);
    chk("loads_final", loads, 4);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Upstream time-entry stage for the 24-hour clock display block. It debounces three board push-buttons and runs a small edit state machine that lets the user step an hour field and a minute field. It then commits both with a one-cycle `load` pulse on `h`/`m`, the clock block's load interface. Produced values are always in range (h < 24, m < 60), so the clock block's `fault` never asserts from this source.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required before a key change is accepted (20 ms at 50 MHz). Must be ≥ 2.
- `clk_50`  input  1  system clock, 50 MHz
- `clr`  input  1  reset, synchronous, active-high
- `key_mode_n`  input  1  raw mode key, active-low, asynchronous to `clk_50`
- `key_up_n`  input  1  raw increment key, active-low, asynchronous
- `key_down_n`  input  1  raw decrement key, active-low, asynchronous
- `h`  output  5  staged hour value, 0–23
- `m`  output  6  staged minute value, 0–59
- `load`  output  1  one-cycle commit strobe, qualifies `h`/`m`
- `edit_h`  output  1  high while the hour field is being edited (for display blink)
- `edit_m`  output  1  high while the minute field is being edited

## Operation
- Reset, with `clr` high at a rising edge: state IDLE, `h`=0, `m`=0, `load`=0, `edit_h`=0, `edit_m`=0. All debouncers reset to released level and count 0; the synchronizer flops reset to 1 (released).
- Per key:
  - 2-flop synchronizer.
  - Debouncer: the counter increments while the synchronized level differs from the debounced level and clears otherwise. When the count reaches `DEBOUNCE_CYCLES` the debounced level flips and the counter clears.
  - Press event: a one-cycle pulse on the debounced released→pressed transition only. Releases generate no event.
  - A held key gives exactly one event; there is no auto-repeat.
- States:
  - IDLE: mode event → SET_H. Up/down events are ignored.
  - SET_H: `edit_h`=1. Up: `h` = (h==23) ? 0 : h+1. Down: `h` = (h==0) ? 23 : h−1. Mode event → SET_M.
  - SET_M: `edit_m`=1. Up: `m` = (m==59) ? 0 : m+1. Down: `m` = (m==0) ? 59 : m−1. Mode event → COMMIT.
  - COMMIT: `load`=1 for exactly this one cycle, then unconditionally → IDLE. Events arriving in this cycle are dropped.
- Event priority within one cycle:
  - Mode beats up/down. The state advances and the field is not changed.
  - Up and down together with no mode: no change.
- `h`/`m` hold their values after a commit. The next edit session starts from the last staged values, not from 0.
- `edit_h`/`edit_m` are decoded from state. Both are 0 in IDLE and COMMIT, and never both 1.
- All arithmetic stays in field width. Wrap is by explicit compare, not by modulo of the natural width, so 24–31 and 60–63 are unreachable.

## Timing
- All outputs are registered and change only on rising `clk_50`.
- Key latency: raw key falls and is first sampled at edge N. The synchronized level changes at edge N+1 and the counter counts from edge N+2. The debounced level flips at edge N+1+`DEBOUNCE_CYCLES`. The event pulse is high for the cycle after that edge. The state/field update lands on edge N+2+`DEBOUNCE_CYCLES`.
- Bounce shorter than `DEBOUNCE_CYCLES` cycles restarts the count and produces no event.
- `load` is high for one cycle, the cycle after the edge that entered COMMIT. `h`/`m` are stable during that cycle and stay stable after it.
- Minimum spacing between accepted events on one key is 2×`DEBOUNCE_CYCLES` + 2 cycles (press then release).
- Reset mid-edit, in any state: on the next edge the block returns to IDLE with `h`=`m`=0, no `load` pulse is issued, and partially filtered key presses are discarded.
- A `clr` in the same cycle as the COMMIT state: reset wins and `load` drops to 0 on that edge.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- Reset, then hold all keys released for 50 cycles → `h`=0, `m`=0, `load`, `edit_h` and `edit_m` all stay 0.
- Mode, 5×up, mode, 3×down, mode → `edit_h` then `edit_m` sequence seen; one `load` pulse with `h`=5, `m`=57; IDLE afterwards.
- Wrap check: in SET_H from 23 press up → `h`=0, then down → `h`=23. In SET_M from 59 press up → `m`=0.
- Bounce: `key_up_n` toggles low for 3 cycles, high for 1, then low and held → exactly one increment, landing on edge N+2+4 counted from the final stable low sample. Holding for 200 more cycles → no further change.
- Simultaneous events: up and down debounced pressed in the same cycle in SET_M → `m` unchanged. Mode and up together in SET_H → state moves to SET_M with `h` unchanged.
- Reset mid-edit: in SET_M with `h`=7, `m`=30, assert `clr` for 1 cycle → next cycle IDLE, `h`=0, `m`=0, no `load` pulse.
